// File: rtl/map_tile_rmw_arbiter_if.sv
// Requester and RAM port-B bundle for the tile-map read-modify-write arbiter.
// The master side holds the requesters and RAM; the slave side is the arbiter.
interface map_tile_rmw_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ROW_W = 160
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_we;
  logic [N_REQ*6-1:0] req_x;
  logic [N_REQ*5-1:0] req_y;
  logic [N_REQ*4-1:0] req_tile;
  logic [N_REQ-1:0]   ack;
  logic [3:0]         rd_tile;
  logic               err;
  logic               busy;
  logic [4:0]         ram_addr;
  logic [ROW_W-1:0]   ram_wrdata;
  logic               ram_wren;
  logic [ROW_W-1:0]   ram_rddata;

  modport master (
    output req, req_we, req_x, req_y, req_tile, ram_rddata,
    input  ack, rd_tile, err, busy, ram_addr, ram_wrdata, ram_wren
  );

  modport slave (
    input  req, req_we, req_x, req_y, req_tile, ram_rddata,
    output ack, rd_tile, err, busy, ram_addr, ram_wrdata, ram_wren
  );
endinterface

// File: rtl/map_tile_rmw_arbiter.sv
// Round-robin arbiter that serialises single-tile read-modify-write accesses onto
// tile-map RAM port B; one access in flight, RD_LAT+3 cycles per access.
module map_tile_rmw_arbiter #(
  parameter int N_REQ  = 4,
  parameter int COLS   = 40,
  parameter int ROWS   = 30,
  parameter int ROW_W  = 160,
  parameter int RD_LAT = 2
) (
  input logic                   CLOCK_50,
  input logic                   reset_n,
  map_tile_rmw_arbiter_if.slave bus
);

  localparam int G_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int C_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, READ, MODIFY, WRITE} state_t;

  state_t           state, state_nx;
  logic [G_W-1:0]   rr_ptr;
  logic [G_W-1:0]   g;
  logic [C_W-1:0]   cnt;
  logic [5:0]       x_q;
  logic [3:0]       tile_q;
  logic             we_q;
  logic             bad_q;
  logic [3:0]       old_q;
  logic [4:0]       addr_q;
  logic [ROW_W-1:0] wrdata_q;

  logic             gnt_vld;
  logic [G_W-1:0]   gnt_idx;
  logic [5:0]       gnt_x;
  logic [4:0]       gnt_y;
  logic [3:0]       gnt_tile;
  logic             gnt_we;
  logic             gnt_bad;
  logic [ROW_W-1:0] row_mod;
  logic [3:0]       row_old;
  logic [N_REQ-1:0] ack_vec;

  // First pending requester at or above rr_ptr, wrapping at N_REQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_vld && bus.req[(int'(rr_ptr) + k) % N_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = G_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    gnt_x    = '0;
    gnt_y    = '0;
    gnt_tile = '0;
    gnt_we   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == G_W'(i)) begin
        gnt_x    = bus.req_x[6*i +: 6];
        gnt_y    = bus.req_y[5*i +: 5];
        gnt_tile = bus.req_tile[4*i +: 4];
        gnt_we   = bus.req_we[i];
      end
    end
    gnt_bad = (gnt_x >= 6'(COLS)) || (gnt_y >= 5'(ROWS));
  end

  // Splice the new code into nibble x; x=0 is the most significant nibble.
  always_comb begin
    row_mod = bus.ram_rddata;
    row_old = '0;
    for (int c = 0; c < COLS; c++) begin
      if (x_q == 6'(c)) begin
        row_old                    = bus.ram_rddata[ROW_W-1-4*c -: 4];
        row_mod[ROW_W-1-4*c -: 4]  = tile_q;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_vld) state_nx = gnt_bad ? WRITE : READ;
      READ:    if (cnt == C_W'(RD_LAT - 1)) state_nx = MODIFY;
      MODIFY:  state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      g        <= '0;
      cnt      <= '0;
      x_q      <= '0;
      tile_q   <= '0;
      we_q     <= 1'b0;
      bad_q    <= 1'b0;
      old_q    <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            g      <= gnt_idx;
            x_q    <= gnt_x;
            tile_q <= gnt_tile;
            we_q   <= gnt_we;
            bad_q  <= gnt_bad;
            addr_q <= gnt_y;
            cnt    <= '0;
          end
        end
        READ:   cnt <= cnt + 1'b1;
        MODIFY: begin
          old_q    <= row_old;
          wrdata_q <= row_mod;
        end
        WRITE:  rr_ptr <= (g == G_W'(N_REQ - 1)) ? '0 : g + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (state == WRITE && g == G_W'(i)) ack_vec[i] = 1'b1;
    end
  end

  assign bus.ack        = ack_vec;
  assign bus.rd_tile    = (state == WRITE && !bad_q) ? old_q : 4'h0;
  assign bus.err        = (state == WRITE) && bad_q;
  assign bus.ram_wren   = (state == WRITE) && we_q && !bad_q;
  assign bus.busy       = (state != IDLE);
  assign bus.ram_addr   = addr_q;
  assign bus.ram_wrdata = wrdata_q;

endmodule

// File: tb/tb_map_tile_rmw_arbiter.sv
// Directed bench: drives requesters against a 2-cycle-latency RAM model and
// checks grant order, latency, spliced write rows, error and reset responses.
module tb_map_tile_rmw_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  map_tile_rmw_arbiter_if bus ();
  map_tile_rmw_arbiter dut (.CLOCK_50(clk), .reset_n(reset_n), .bus(bus));

  logic [159:0] mem [0:31];
  logic [159:0] d1, d2;
  always @(posedge clk) begin
    d1 <= mem[bus.ram_addr];
    d2 <= d1;
    if (bus.ram_wren === 1'b1) mem[bus.ram_addr] <= bus.ram_wrdata;
  end
  assign bus.ram_rddata = d2;

  int wren_cnt = 0;
  int ack_cnt  = 0;
  always @(posedge clk) begin
    if (bus.ram_wren === 1'b1) wren_cnt++;
    if (bus.ack != 0) ack_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.ack == 0 && n < 40);
  endtask

  task automatic set_req(input int i, input logic on, input logic we,
                         input logic [5:0] x, input logic [4:0] y, input logic [3:0] t);
    bus.req[i]          = on;
    bus.req_we[i]       = we;
    bus.req_x[6*i +: 6] = x;
    bus.req_y[5*i +: 5] = y;
    bus.req_tile[4*i +: 4] = t;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int w0;
    int a0;
    logic [159:0] e;
    logic [3:0] exp_ack;

    bus.req = '0; bus.req_we = '0; bus.req_x = '0; bus.req_y = '0; bus.req_tile = '0;
    for (int r = 0; r < 32; r++) mem[r] = '0;
    e = {40{4'h1}};
    mem[3] = e;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", bus.ack, 0);
    check("rst_err", bus.err, 0);
    check("rst_rd_tile", bus.rd_tile, 0);
    check("rst_wren", bus.ram_wren, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_wrdata", bus.ram_wrdata, 0);
    check("rst_busy", bus.busy, 0);
    reset_n = 1'b1;

    // 1: write tile 0 of an all-ones row
    set_req(0, 1'b1, 1'b1, 6'd0, 5'd3, 4'h5);
    wait_ack(n);
    check("t1_lat", n, 4);
    check("t1_ack", bus.ack, 4'b0001);
    check("t1_addr", bus.ram_addr, 3);
    check("t1_wren", bus.ram_wren, 1);
    e = {4'h5, {39{4'h1}}};
    check("t1_wrdata", bus.ram_wrdata, e);
    check("t1_rd_tile", bus.rd_tile, 4'h1);
    check("t1_err", bus.err, 0);
    set_req(0, 1'b0, 1'b0, 6'd0, 5'd0, 4'h0);
    idle_cycle();
    check("t1_wren_off", bus.ram_wren, 0);
    check("t1_idle", bus.busy, 0);

    // 2: last tile of last row, then a read-only probe of it
    set_req(1, 1'b1, 1'b1, 6'd39, 5'd29, 4'hA);
    wait_ack(n);
    check("t2_lat", n, 4);
    check("t2_ack", bus.ack, 4'b0010);
    check("t2_wrdata", bus.ram_wrdata, 160'hA);
    set_req(1, 1'b0, 1'b0, 6'd39, 5'd29, 4'h0);
    idle_cycle();
    w0 = wren_cnt;
    set_req(1, 1'b1, 1'b0, 6'd39, 5'd29, 4'h0);
    wait_ack(n);
    check("t2p_lat", n, 4);
    check("t2p_ack", bus.ack, 4'b0010);
    check("t2p_rd_tile", bus.rd_tile, 4'hA);
    check("t2p_wren", bus.ram_wren, 0);
    set_req(1, 1'b0, 1'b0, 6'd39, 5'd29, 4'h0);
    idle_cycle();
    check("t2p_no_write", wren_cnt, w0);

    // 3: all four requesting from reset, served in order
    reset_n = 1'b0;
    idle_cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 6'(i), 5'(i), 4'h0);
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      exp_ack = 4'(1 << k);
      check("t3_ack", bus.ack, exp_ack);
      check("t3_gap", n, (k == 0) ? 4 : 5);
      bus.req[k] = 1'b0;
    end
    bus.req = 4'b1001;
    wait_ack(n);
    check("t3b_ack0", bus.ack, 4'b0001);
    check("t3b_gap0", n, 5);
    bus.req[0] = 1'b0;
    wait_ack(n);
    check("t3b_ack3", bus.ack, 4'b1000);
    check("t3b_gap3", n, 5);
    bus.req[3] = 1'b0;
    idle_cycle();

    // 4: out-of-range column and row
    w0 = wren_cnt;
    set_req(2, 1'b1, 1'b1, 6'd40, 5'd0, 4'h3);
    wait_ack(n);
    check("t4x_lat", n, 1);
    check("t4x_ack", bus.ack, 4'b0100);
    check("t4x_err", bus.err, 1);
    check("t4x_rd_tile", bus.rd_tile, 0);
    set_req(2, 1'b0, 1'b0, 6'd0, 5'd0, 4'h0);
    idle_cycle();
    set_req(2, 1'b1, 1'b1, 6'd0, 5'd30, 4'h3);
    wait_ack(n);
    check("t4y_lat", n, 1);
    check("t4y_ack", bus.ack, 4'b0100);
    check("t4y_err", bus.err, 1);
    set_req(2, 1'b0, 1'b0, 6'd0, 5'd0, 4'h0);
    idle_cycle();
    check("t4_no_write", wren_cnt, w0);
    check("t4_err_off", bus.err, 0);

    // 5: reset during READ aborts the access
    w0 = wren_cnt;
    a0 = ack_cnt;
    set_req(0, 1'b1, 1'b1, 6'd1, 5'd5, 4'hF);
    repeat (2) idle_cycle();
    check("t5_busy", bus.busy, 1);
    reset_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 6'd0, 5'd0, 4'h0);
    idle_cycle();
    check("t5_busy_rst", bus.busy, 0);
    check("t5_addr_rst", bus.ram_addr, 0);
    check("t5_wrdata_rst", bus.ram_wrdata, 0);
    check("t5_ack_rst", bus.ack, 0);
    reset_n = 1'b1;
    repeat (6) idle_cycle();
    check("t5_no_wren", wren_cnt, w0);
    check("t5_no_ack", ack_cnt, a0);
    check("t5_mem_intact", mem[5], 0);
    // rr_ptr was 3 before reset; back at 0 means requester 0 wins over 3
    set_req(0, 1'b1, 1'b1, 6'd2, 5'd6, 4'h7);
    set_req(3, 1'b1, 1'b0, 6'd2, 5'd6, 4'h0);
    wait_ack(n);
    check("t5_lat", n, 4);
    check("t5_ack0", bus.ack, 4'b0001);
    e = {8'h00, 4'h7, 148'h0};
    check("t5_wrdata", bus.ram_wrdata, e);
    bus.req[0] = 1'b0;
    wait_ack(n);
    check("t5_ack3", bus.ack, 4'b1000);
    check("t5_rd_tile3", bus.rd_tile, 4'h7);
    bus.req[3] = 1'b0;
    idle_cycle();

    // 6: fields latched at grant, req withdrawn mid-flight, waiter served next
    set_req(0, 1'b1, 1'b1, 6'd10, 5'd7, 4'hC);
    set_req(1, 1'b1, 1'b1, 6'd3, 5'd7, 4'h9);
    idle_cycle();
    bus.req_x[5:0]    = 6'd20;
    bus.req_tile[3:0] = 4'h2;
    bus.req[0]        = 1'b0;
    wait_ack(n);
    check("t6_lat", n, 3);
    check("t6_ack0", bus.ack, 4'b0001);
    e = {156'h0, 4'hC} << 116;
    check("t6_wrdata0", bus.ram_wrdata, e);
    wait_ack(n);
    check("t6_ack1", bus.ack, 4'b0010);
    check("t6_gap", n, 5);
    e = ({156'h0, 4'h9} << 144) | ({156'h0, 4'hC} << 116);
    check("t6_wrdata1", bus.ram_wrdata, e);
    bus.req[1] = 1'b0;
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
